div_stage_reg: RTL and testbench
================================

Name: div_stage_reg

Overview:
- Registered handshake stage placed between two consecutive combinational divider slices in the pipelined N-bit divider.
- Captures the upstream slice's partial remainder, pass-through divisor and quotient bit.
- Merges that quotient bit into the running quotient accumulator and presents the result to the next slice.
- Provides valid/ready flow control with a 2-entry skid buffer, so the pipeline sustains one division per cycle under backpressure with no combinational ready path.

Parameters:
- SHIFT, 5, bit position of the quotient bit produced by the upstream slice; merged at this index.
- DIVIDENDLEN, 16, dividend width.
- DIVISORLEN, 8, divisor width.
- TAGLEN, 4, width of the user tag carried alongside each operation.
- DATAPATHLEN (localparam), DIVIDENDLEN+DIVISORLEN-1, remainder/quotient datapath width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream slice holds a valid operation.
- in_ready  output  1  stage can accept this cycle.
- in_rem  input  DATAPATHLEN  partial remainder from the upstream slice.
- in_div  input  DIVISORLEN  divisor passed through by the upstream slice.
- in_qbit  input  1  quotient bit from the upstream slice.
- in_quot  input  DATAPATHLEN  quotient accumulated by earlier stages.
- in_dz  input  1  divide-by-zero flag, carried through.
- in_tag  input  TAGLEN  user tag, carried through.
- out_valid  output  1  output fields are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_rem  output  DATAPATHLEN  registered remainder.
- out_div  output  DIVISORLEN  registered divisor.
- out_quot  output  DATAPATHLEN  in_quot with bit SHIFT set to in_qbit.
- out_dz  output  1  registered in_dz.
- out_tag  output  TAGLEN  registered in_tag.

Behaviour:
- Merge rule: out_quot = in_quot with bit SHIFT replaced by in_qbit; all other bits are copied unchanged.
  - The merge is computed before capture, so both the main and skid entries hold merged values.
- Storage: a main register (drives the out_* ports) and a skid register, each with its own valid bit.
- in_ready = NOT skid_valid. It is registered-derived, with no combinational path from out_ready.
- Accept occurs when in_valid AND in_ready. Emit occurs when out_valid AND out_ready.
- States:
  - EMPTY (main invalid, skid invalid)
  - ONE (main valid, skid invalid)
  - FULL (main valid, skid valid)
- EMPTY: accept -> load main, go to ONE. No accept -> stay in EMPTY.
- ONE:
  - accept and emit -> load main with new data, stay in ONE.
  - accept, no emit -> load skid, go to FULL.
  - emit, no accept -> go to EMPTY.
  - neither -> hold.
- FULL: in_ready=0, so no accept. Emit -> move skid to main, go to ONE. No emit -> hold.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 operation/cycle while out_ready=1.
- Ordering is strictly FIFO; operations are never dropped or duplicated.
- out_* fields are stable while out_valid=1 and out_ready=0.
- When out_valid=0, data outputs hold their last values. Verification must not check them in that state.
- in_* fields are ignored when not accepted.
- Reset (asserted at any time, including mid-operation):
  - Immediately clears both valid bits and zeroes all data registers.
  - Resulting outputs: out_valid=0 and all data outputs 0; in_ready=1.
  - All in-flight operations are discarded.
  - The first accept is possible on the first rising edge after rst_n deasserts.
- No arithmetic is performed besides the bit merge. Widths are passed through unchanged, with no truncation.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_* =0, in_ready=1. Release rst_n, then drive in_valid=1 for one cycle -> out_valid=1 on the next edge.
- Single op (defaults): in_rem=76, in_div=7, in_qbit=1, in_quot=0x40, in_tag=3, out_ready=1 -> one cycle later out_rem=76, out_div=7, out_quot=0x60, out_tag=3, out_valid=1. With in_qbit=0 and in_quot=0x20 -> out_quot=0x00.
- Streaming: 8 back-to-back ops with tags 0..7 and out_ready=1 throughout -> 8 consecutive out_valid cycles, tags 0..7 in order, in_ready=1 throughout.
- Backpressure: out_ready=0 while sending tags 1,2 -> state FULL, in_ready=0, out_tag=1 held stable. Tag 3 is offered and not accepted. Raise out_ready -> outputs tags 1,2,3 in order, no loss.
- Reset mid-operation: assert rst_n=0 while FULL -> out_valid=0 and in_ready=1 immediately, asynchronously without a clock edge. After release, no stale tags appear.
- Random valid/ready stress (≥1000 ops, scoreboard on tag/quot/rem) -> exact in-order match, and stable outputs whenever out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/div_stage_reg.sv
// Registered handshake stage between two divider slices: merges the upstream
// quotient bit into the running quotient and buffers through a 2-entry skid.
module div_stage_reg #(
   parameter int SHIFT       = 5,
   parameter int DIVIDENDLEN = 16,
   parameter int DIVISORLEN  = 8,
   parameter int TAGLEN      = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DIVIDENDLEN+DIVISORLEN-2:0]   in_rem,
   input  logic [DIVISORLEN-1:0]               in_div,
   input  logic                                in_qbit,
   input  logic [DIVIDENDLEN+DIVISORLEN-2:0]   in_quot,
   input  logic                                in_dz,
   input  logic [TAGLEN-1:0]                   in_tag,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DIVIDENDLEN+DIVISORLEN-2:0]   out_rem,
   output logic [DIVISORLEN-1:0]               out_div,
   output logic [DIVIDENDLEN+DIVISORLEN-2:0]   out_quot,
   output logic                                out_dz,
   output logic [TAGLEN-1:0]                   out_tag
);

   localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;
   localparam int ENTRY_W     = 2 * DATAPATHLEN + DIVISORLEN + 1 + TAGLEN;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   function automatic logic [DATAPATHLEN-1:0] merge_qbit(
      input logic [DATAPATHLEN-1:0] quot,
      input logic                   qbit
   );
      logic [DATAPATHLEN-1:0] merged;
      merged        = quot;
      merged[SHIFT] = qbit;
      return merged;
   endfunction

   logic [1:0]         state;
   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] main_p1;
   logic [ENTRY_W-1:0] skid_p1;
   logic               accept;
   logic               emit;

   // Merge happens before capture so main and skid both hold final values.
   assign in_entry  = {in_rem, in_div, merge_qbit(in_quot, in_qbit), in_dz, in_tag};

   // Ready depends only on the registered state, never on out_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   // Stage boundary: main entry drives the outputs, skid absorbs one extra op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         main_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_p1 <= in_entry;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_p1 <= in_entry;
               end else if (accept) begin
                  skid_p1 <= in_entry;
                  state   <= FULL;
               end else if (emit) begin
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (emit) begin
                  main_p1 <= skid_p1;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign {out_rem, out_div, out_quot, out_dz, out_tag} = main_p1;

endmodule

// File: tb/tb_div_stage_reg.sv
// Directed and randomized handshake bench for div_stage_reg with a FIFO
// reference model for ordering, merge and hold-stability.
module tb_div_stage_reg;

   localparam int DPL = 23;

   typedef struct packed {
      logic [DPL-1:0] rem;
      logic [7:0]     div;
      logic [DPL-1:0] quot;
      logic           dz;
      logic [3:0]     tag;
   } entry_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [DPL-1:0] in_rem;
   logic [7:0]     in_div;
   logic           in_qbit;
   logic [DPL-1:0] in_quot;
   logic           in_dz;
   logic [3:0]     in_tag;
   logic           out_valid;
   logic           out_ready;
   logic [DPL-1:0] out_rem;
   logic [7:0]     out_div;
   logic [DPL-1:0] out_quot;
   logic           out_dz;
   logic [3:0]     out_tag;

   int checks = 0;
   int errors = 0;

   div_stage_reg #(.SHIFT(5), .DIVIDENDLEN(16), .DIVISORLEN(8), .TAGLEN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rem(in_rem), .in_div(in_div), .in_qbit(in_qbit), .in_quot(in_quot),
      .in_dz(in_dz), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rem(out_rem), .out_div(out_div), .out_quot(out_quot),
      .out_dz(out_dz), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DPL-1:0] rem, input logic [7:0] dv,
                        input logic qb, input logic [DPL-1:0] qt, input logic dz,
                        input logic [3:0] tg);
      in_valid = v; in_rem = rem; in_div = dv; in_qbit = qb;
      in_quot = qt; in_dz = dz; in_tag = tg;
   endtask

   entry_t q[$];
   entry_t e;
   entry_t prev_out;
   logic   hold;
   logic   acc_m, emit_m;
   int     ops;

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 23'd11, 8'd2, 1'b1, 23'h1, 1'b1, 4'hA);
      cycle(); cycle();
      // reset state while in_valid is high
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_rem", 64'(out_rem), 64'd0);
      chk("rst_out_div", 64'(out_div), 64'd0);
      chk("rst_out_quot", 64'(out_quot), 64'd0);
      chk("rst_out_dz", 64'(out_dz), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);

      // first accept right after release; single op with defaults
      rst_n = 1'b1;
      drive(1'b1, 23'd76, 8'd7, 1'b1, 23'h40, 1'b1, 4'd3);
      cycle();
      chk("op1_valid", 64'(out_valid), 64'd1);
      chk("op1_rem", 64'(out_rem), 64'd76);
      chk("op1_div", 64'(out_div), 64'd7);
      chk("op1_quot", 64'(out_quot), 64'h60);
      chk("op1_dz", 64'(out_dz), 64'd1);
      chk("op1_tag", 64'(out_tag), 64'd3);
      drive(1'b1, 23'd100, 8'd9, 1'b0, 23'h20, 1'b0, 4'd4);
      cycle();
      chk("op2_quot", 64'(out_quot), 64'h0);
      chk("op2_tag", 64'(out_tag), 64'd4);
      chk("op2_dz", 64'(out_dz), 64'd0);
      in_valid = 1'b0;
      cycle();
      chk("op2_drained", 64'(out_valid), 64'd0);

      // streaming 8 back-to-back ops
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, DPL'(i * 3), 8'(i + 1), 1'b1, DPL'(0), 1'b0, 4'(i));
         cycle();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_tag", 64'(out_tag), 64'(i));
         chk("stream_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      cycle();
      chk("stream_drained", 64'(out_valid), 64'd0);

      // backpressure fills main and skid
      out_ready = 1'b0;
      drive(1'b1, 23'd1, 8'd1, 1'b0, 23'd0, 1'b0, 4'd1);
      cycle();
      chk("bp_one_tag", 64'(out_tag), 64'd1);
      chk("bp_one_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 23'd2, 8'd2, 1'b0, 23'd0, 1'b0, 4'd2);
      cycle();
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      chk("bp_full_tag", 64'(out_tag), 64'd1);
      drive(1'b1, 23'd3, 8'd3, 1'b0, 23'd0, 1'b0, 4'd3);
      cycle();
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_tag", 64'(out_tag), 64'd1);
      chk("bp_hold_rem", 64'(out_rem), 64'd1);
      out_ready = 1'b1;
      cycle();
      chk("bp_drain_tag2", 64'(out_tag), 64'd2);
      chk("bp_drain_rem2", 64'(out_rem), 64'd2);
      chk("bp_drain_ready", 64'(in_ready), 64'd1);
      cycle();
      chk("bp_drain_tag3", 64'(out_tag), 64'd3);
      chk("bp_drain_valid3", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      cycle();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // asynchronous reset while FULL
      out_ready = 1'b0;
      drive(1'b1, 23'd5, 8'd5, 1'b1, 23'd0, 1'b0, 4'd5);
      cycle();
      drive(1'b1, 23'd6, 8'd6, 1'b1, 23'd0, 1'b0, 4'd6);
      cycle();
      chk("mid_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_tag", 64'(out_tag), 64'd0);
      cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      cycle();
      chk("post_rst_no_stale2", 64'(out_valid), 64'd0);
      drive(1'b1, 23'd9, 8'd9, 1'b0, 23'h7FFFFF, 1'b0, 4'd9);
      cycle();
      chk("post_rst_tag", 64'(out_tag), 64'd9);
      chk("post_rst_quot", 64'(out_quot), 64'h7FFFDF);
      in_valid = 1'b0;
      cycle();

      // randomized valid/ready against a FIFO model
      ops = 0;
      hold = 1'b0;
      prev_out = '0;
      for (int c = 0; c < 6000 && ops < 1000; c++) begin
         drive($urandom_range(0, 3) != 0, DPL'($urandom), 8'($urandom), 1'($urandom),
               DPL'($urandom), 1'($urandom), 4'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("rnd_out_entry", 64'({out_rem, out_div, out_quot, out_dz, out_tag}), 64'(q[0]));
         end
         if (hold) begin
            chk("rnd_hold_stable", 64'({out_rem, out_div, out_quot, out_dz, out_tag}), 64'(prev_out));
         end
         acc_m  = in_valid && (q.size() < 2);
         emit_m = (q.size() > 0) && out_ready;
         hold   = (q.size() > 0) && !out_ready;
         prev_out = {out_rem, out_div, out_quot, out_dz, out_tag};
         if (emit_m) void'(q.pop_front());
         if (acc_m) begin
            e.rem  = in_rem;
            e.div  = in_div;
            e.quot = in_qbit ? (in_quot | DPL'(32)) : (in_quot & ~DPL'(32));
            e.dz   = in_dz;
            e.tag  = in_tag;
            q.push_back(e);
            ops++;
         end
         cycle();
      end
      chk("rnd_op_count_reached", 64'(ops >= 1000), 64'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4 && q.size() > 0; c++) begin
         chk("rnd_drain_entry", 64'({out_rem, out_div, out_quot, out_dz, out_tag}), 64'(q[0]));
         void'(q.pop_front());
         cycle();
      end
      chk("rnd_final_empty", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
